// File: rtl/full_adder_using_half_adder_if.sv
// ---------------------------------------------------------------------------
// full_adder_using_half_adder_if
//
// Bundles the operand and result signals of full_adder_using_half_adder so
// the adder and whatever drives it share a single port.
//
// Signals:
//   a, b       WIDTH  operands, unsigned
//   cin        1      carry into bit 0
//   in_valid   1      qualifies a/b/cin for capture into the register stage
//   sum        WIDTH  combinational sum
//   carry      1      combinational carry out of the MSB slice
//   sum_q      WIDTH  registered sum
//   carry_q    1      registered carry
//   out_valid  1      high one cycle after an accepted in_valid
//
// Modports:
//   master  drives operands, observes results (testbench / upstream logic)
//   slave   observes operands, drives results (the adder itself)
// ---------------------------------------------------------------------------
interface full_adder_using_half_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, carry, sum_q, carry_q, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, carry, sum_q, carry_q, out_valid
    );
endinterface

// File: rtl/full_adder_using_half_adder.sv
// ---------------------------------------------------------------------------
// full_adder_using_half_adder
//
// WIDTH-bit ripple-carry adder. Each bit slice is a full adder made of two
// half adders and an OR. The result is available combinationally with zero
// latency and also as a registered copy one clock later.
//
// Ports:
//   clk    rising-edge clock for the output register stage
//   rst_n  asynchronous active-low reset (clears the register stage only)
//   bus    full_adder_using_half_adder_if.slave
//            in : a, b, cin, in_valid
//            out: sum, carry (combinational), sum_q, carry_q, out_valid
// ---------------------------------------------------------------------------
module full_adder_using_half_adder #(
    parameter int WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    full_adder_using_half_adder_if.slave   bus
);

    // Half adder cell, returned as {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // carry_chain[i] is the carry into slice i; carry_chain[WIDTH] is the
    // carry out of the MSB slice.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic [WIDTH-1:0] sum_w;

    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             valid_r;

    assign carry_chain[0] = bus.cin;

    // First half adder combines the operand bits, the second folds in the
    // incoming carry; either half adder can generate the slice carry, and
    // they can never both do so, so a plain OR merges them.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign {c1[i], s1[i]}    = half_add(bus.a[i], bus.b[i]);
        assign {c2[i], sum_w[i]} = half_add(s1[i], carry_chain[i]);
        assign carry_chain[i+1]  = c1[i] | c2[i];
    end

    // Output register stage. The data registers only load on accepted
    // operations so the last result stays visible while in_valid is low;
    // out_valid is a pure one-cycle-delayed copy of in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            carry_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                sum_r   <= sum_w;
                carry_r <= carry_chain[WIDTH];
            end
        end
    end

    assign bus.sum       = sum_w;
    assign bus.carry     = carry_chain[WIDTH];
    assign bus.sum_q     = sum_r;
    assign bus.carry_q   = carry_r;
    assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_full_adder_using_half_adder.sv
// ---------------------------------------------------------------------------
// tb_full_adder_using_half_adder
//
// Drives three instances of full_adder_using_half_adder (WIDTH = 1, 8, 4)
// with directed vectors and compares every result against hand-computed or
// arithmetically computed expectations.
// ---------------------------------------------------------------------------
module tb_full_adder_using_half_adder;

    logic clk;
    logic rst_n;

    int testCount;
    int failCount;

    full_adder_using_half_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_using_half_adder_if #(.WIDTH(8)) bus8 ();
    full_adder_using_half_adder_if #(.WIDTH(4)) bus4 ();

    full_adder_using_half_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    full_adder_using_half_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    full_adder_using_half_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    vec_t vec1 [8];
    vec_t vec8 [7];

    // Single comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one instance's inputs; which selects the instance width (1/8/4).
    task automatic applyStimulus(input int which, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin,
                                 input logic in_valid);
        case (which)
            1: begin
                bus1.a = a[0:0]; bus1.b = b[0:0];
                bus1.cin = cin;  bus1.in_valid = in_valid;
            end
            8: begin
                bus8.a = a; bus8.b = b;
                bus8.cin = cin; bus8.in_valid = in_valid;
            end
            default: begin
                bus4.a = a[3:0]; bus4.b = b[3:0];
                bus4.cin = cin;  bus4.in_valid = in_valid;
            end
        endcase
    endtask

    initial begin
        logic [4:0] expected4;

        testCount = 0;
        failCount = 0;

        vec1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0};
        vec1[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0};
        vec1[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0};
        vec1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1};
        vec1[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0};
        vec1[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1};
        vec1[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1};
        vec1[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1};

        vec8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vec8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vec8[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vec8[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vec8[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vec8[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vec8[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        rst_n = 1'b0;
        applyStimulus(1, 8'h0, 8'h0, 1'b0, 1'b0);
        applyStimulus(8, 8'h0, 8'h0, 1'b0, 1'b0);
        applyStimulus(4, 8'h0, 8'h0, 1'b0, 1'b0);

        // Reset state of the register stage
        #2;
        checkOutput("rst_sum_q_w1",     32'(bus1.sum_q),     32'h0);
        checkOutput("rst_carry_q_w1",   32'(bus1.carry_q),   32'h0);
        checkOutput("rst_out_valid_w1", 32'(bus1.out_valid), 32'h0);
        checkOutput("rst_out_valid_w8", 32'(bus8.out_valid), 32'h0);
        checkOutput("rst_sum_q_w8",     32'(bus8.sum_q),     32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table, one vector every 10 ns
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, vec1[i].a, vec1[i].b, vec1[i].cin, 1'b0);
            #1;
            checkOutput($sformatf("w1_sum_%0d", i),   32'(bus1.sum),   32'(vec1[i].sum));
            checkOutput($sformatf("w1_carry_%0d", i), 32'(bus1.carry), 32'(vec1[i].carry));
            #9;
        end

        // WIDTH=1 capture of 1+1+1, then hold with in_valid low
        @(negedge clk);
        applyStimulus(1, 8'h1, 8'h1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("w1_cap_sum_q",     32'(bus1.sum_q),     32'h1);
        checkOutput("w1_cap_carry_q",   32'(bus1.carry_q),   32'h1);
        checkOutput("w1_cap_out_valid", 32'(bus1.out_valid), 32'h1);
        @(negedge clk);
        applyStimulus(1, 8'h0, 8'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("w1_hold_out_valid", 32'(bus1.out_valid), 32'h0);
        checkOutput("w1_hold_sum_q",     32'(bus1.sum_q),     32'h1);
        checkOutput("w1_hold_carry_q",   32'(bus1.carry_q),   32'h1);

        // Asynchronous reset between edges: registers clear, comb path lives on
        @(negedge clk);
        applyStimulus(1, 8'h1, 8'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_sum_q",     32'(bus1.sum_q),     32'h0);
        checkOutput("arst_carry_q",   32'(bus1.carry_q),   32'h0);
        checkOutput("arst_out_valid", 32'(bus1.out_valid), 32'h0);
        checkOutput("arst_comb_sum",   32'(bus1.sum),   32'h0);
        checkOutput("arst_comb_carry", 32'(bus1.carry), 32'h1);
        applyStimulus(1, 8'h1, 8'h1, 1'b1, 1'b1);
        #1;
        checkOutput("arst_track_sum",   32'(bus1.sum),   32'h1);
        checkOutput("arst_track_carry", 32'(bus1.carry), 32'h1);

        // Held in reset across a rising edge even with in_valid high
        @(posedge clk);
        #1;
        checkOutput("arst_held_out_valid", 32'(bus1.out_valid), 32'h0);
        checkOutput("arst_held_sum_q",     32'(bus1.sum_q),     32'h0);
        checkOutput("arst_held_carry_q",   32'(bus1.carry_q),   32'h0);

        // First capture on first rising edge after release: 1+1+0 = {1,0}
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 8'h1, 8'h1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("rel_out_valid", 32'(bus1.out_valid), 32'h1);
        checkOutput("rel_carry_q",   32'(bus1.carry_q),   32'h1);
        checkOutput("rel_sum_q",     32'(bus1.sum_q),     32'h0);
        @(negedge clk);
        applyStimulus(1, 8'h0, 8'h0, 1'b0, 1'b0);

        // WIDTH=8 combinational vectors, including wrap-around cases
        for (int i = 0; i < 7; i++) begin
            applyStimulus(8, vec8[i].a, vec8[i].b, vec8[i].cin, 1'b0);
            #1;
            checkOutput($sformatf("w8_sum_%0d", i),   32'(bus8.sum),   32'(vec8[i].sum));
            checkOutput($sformatf("w8_carry_%0d", i), 32'(bus8.carry), 32'(vec8[i].carry));
            #9;
        end

        // WIDTH=8 back-to-back captures over three cycles
        @(negedge clk);
        applyStimulus(8, 8'h12, 8'h34, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b0_sum_q",     32'(bus8.sum_q),     32'h46);
        checkOutput("b2b0_carry_q",   32'(bus8.carry_q),   32'h0);
        checkOutput("b2b0_out_valid", 32'(bus8.out_valid), 32'h1);
        @(negedge clk);
        applyStimulus(8, 8'h80, 8'h80, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b1_sum_q",     32'(bus8.sum_q),     32'h01);
        checkOutput("b2b1_carry_q",   32'(bus8.carry_q),   32'h1);
        checkOutput("b2b1_out_valid", 32'(bus8.out_valid), 32'h1);
        @(negedge clk);
        applyStimulus(8, 8'h00, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b2_sum_q",     32'(bus8.sum_q),     32'h00);
        checkOutput("b2b2_carry_q",   32'(bus8.carry_q),   32'h0);
        checkOutput("b2b2_out_valid", 32'(bus8.out_valid), 32'h1);
        @(negedge clk);
        applyStimulus(8, 8'hFF, 8'hFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_out_valid", 32'(bus8.out_valid), 32'h0);
        checkOutput("b2b_idle_sum_q",     32'(bus8.sum_q),     32'h00);

        // WIDTH=4 exhaustive against integer addition
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    applyStimulus(4, 8'(ia), 8'(ib), 1'(ic), 1'b0);
                    expected4 = 5'(ia + ib + ic);
                    #1;
                    checkOutput($sformatf("w4_%0d_%0d_%0d", ia, ib, ic),
                                32'({bus4.carry, bus4.sum}), 32'(expected4));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
